// File: rtl/usb_tx_scheduler.sv
// USB device TX scheduler: arbitrates handshake, retry and data packets toward
// the TX controller, tracks the data toggle and host-handshake retries.
module usb_tx_scheduler #(
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  output logic       hs_grant,
  input  logic       data_req,
  input  logic [6:0] data_size,
  output logic       data_grant,
  output logic       tx_start,
  output logic [2:0] tx_packet,
  output logic [6:0] tx_size,
  input  logic       tx_done,
  input  logic       host_ack,
  input  logic       host_nak,
  input  logic       toggle_clear,
  output logic       busy,
  output logic       xfer_err
);

  localparam int unsigned SIZE_W      = 7;
  localparam int unsigned MAX_PAYLOAD = 64;
  localparam int unsigned CNT_MAX     = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W       = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRY);
  localparam logic [SIZE_W-1:0] SIZE_SAT    = SIZE_W'(MAX_PAYLOAD);

  localparam logic [2:0] PKT_NONE  = 3'b000;
  localparam logic [2:0] PKT_DATA0 = 3'b001;
  localparam logic [2:0] PKT_DATA1 = 3'b010;
  localparam logic [2:0] PKT_ACK   = 3'b011;
  localparam logic [2:0] PKT_NAK   = 3'b100;
  localparam logic [2:0] PKT_STALL = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic              pending_q, pending_d;
  logic              toggle_q, toggle_d;
  logic              is_data_q, is_data_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              hs_grant_q, hs_grant_d;
  logic              data_grant_q, data_grant_d;
  logic              tx_start_q, tx_start_d;
  logic [2:0]        tx_packet_q, tx_packet_d;
  logic [SIZE_W-1:0] tx_size_q, tx_size_d;
  logic              busy_q, busy_d;
  logic              xfer_err_q, xfer_err_d;

  logic [2:0]        hs_code;
  logic [2:0]        data_code;
  logic [SIZE_W-1:0] size_sat;
  logic [RTY_W-1:0]  retry_inc;

  assign data_code = toggle_q ? PKT_DATA1 : PKT_DATA0;
  assign size_sat  = (data_size > SIZE_SAT) ? SIZE_SAT : data_size;
  assign retry_inc = retry_q + RTY_W'(1);

  always_comb begin
    hs_code = PKT_STALL;
    case (hs_type)
      2'b01:   hs_code = PKT_ACK;
      2'b10:   hs_code = PKT_NAK;
      default: hs_code = PKT_STALL;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    pending_d    = pending_q;
    toggle_d     = toggle_q;
    is_data_d    = is_data_q;
    size_d       = size_q;
    tx_packet_d  = tx_packet_q;
    tx_size_d    = tx_size_q;
    hs_grant_d   = 1'b0;
    data_grant_d = 1'b0;
    tx_start_d   = 1'b0;
    xfer_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hs_req && (hs_type != 2'b00)) begin
          state_d     = S_ISSUE;
          is_data_d   = 1'b0;
          hs_grant_d  = 1'b1;
          tx_start_d  = 1'b1;
          tx_packet_d = hs_code;
          tx_size_d   = '0;
        end else if (pending_q) begin
          // Retry reuses the latched size and current toggle, no grant
          state_d     = S_ISSUE;
          is_data_d   = 1'b1;
          tx_start_d  = 1'b1;
          tx_packet_d = data_code;
          tx_size_d   = size_q;
        end else if (data_req) begin
          state_d      = S_ISSUE;
          is_data_d    = 1'b1;
          size_d       = size_sat;
          data_grant_d = 1'b1;
          tx_start_d   = 1'b1;
          tx_packet_d  = data_code;
          tx_size_d    = size_sat;
        end
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tx_done) begin
          tx_packet_d = PKT_NONE;
          tx_size_d   = '0;
          if (is_data_q) begin
            state_d = S_WAIT_ACK;
            cnt_d   = '0;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (host_ack) begin
          toggle_d  = ~toggle_q;
          retry_d   = '0;
          pending_d = 1'b0;
          state_d   = S_GAP;
          cnt_d     = GAP_LOAD;
        end else if (host_nak || (cnt_q == TIMEOUT_LAST)) begin
          if (retry_inc < RETRY_LIMIT) begin
            retry_d   = retry_inc;
            pending_d = 1'b1;
          end else begin
            retry_d    = '0;
            pending_d  = 1'b0;
            xfer_err_d = 1'b1;
          end
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (toggle_clear) begin
      toggle_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      pending_q    <= 1'b0;
      toggle_q     <= 1'b0;
      is_data_q    <= 1'b0;
      size_q       <= '0;
      hs_grant_q   <= 1'b0;
      data_grant_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_packet_q  <= PKT_NONE;
      tx_size_q    <= '0;
      busy_q       <= 1'b0;
      xfer_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pending_q    <= pending_d;
      toggle_q     <= toggle_d;
      is_data_q    <= is_data_d;
      size_q       <= size_d;
      hs_grant_q   <= hs_grant_d;
      data_grant_q <= data_grant_d;
      tx_start_q   <= tx_start_d;
      tx_packet_q  <= tx_packet_d;
      tx_size_q    <= tx_size_d;
      busy_q       <= busy_d;
      xfer_err_q   <= xfer_err_d;
    end
  end

  assign hs_grant   = hs_grant_q;
  assign data_grant = data_grant_q;
  assign tx_start   = tx_start_q;
  assign tx_packet  = tx_packet_q;
  assign tx_size    = tx_size_q;
  assign busy       = busy_q;
  assign xfer_err   = xfer_err_q;

endmodule
